// File: rtl/start_seq_pkg.sv
// Shared types and constants for the program-start sequencer.
// Holds the FSM state encoding, counter width, default parameters and a saturating increment.
package start_seq_pkg;

    localparam int CNT_W = 16;

    localparam int               DEF_NPROG   = 3;
    localparam int               DEF_START_W = 2;
    localparam logic [CNT_W-1:0] DEF_TMO     = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_RUN  = 3'd3,
        S_FIN  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/start_sequencer_if.sv
// Handshake bundle between the session requester, the sequencer and the processor.
// master = sequencer side, slave = requester/processor side.
interface start_sequencer_if;
    import start_seq_pkg::*;

    logic             Go;
    logic             Done;
    logic             Start;
    logic [1:0]       ProgIdx;
    logic             Busy;
    logic [CNT_W-1:0] CycCnt;
    logic             CycVld;
    logic             AllDone;
    logic             TimedOut;

    modport master (
        input  Go, Done,
        output Start, ProgIdx, Busy, CycCnt, CycVld, AllDone, TimedOut
    );

    modport slave (
        output Go, Done,
        input  Start, ProgIdx, Busy, CycCnt, CycVld, AllDone, TimedOut
    );

endinterface

// File: rtl/seq_cyc_ctr.sv
// Clearable run-cycle counter that saturates at all-ones instead of wrapping.
module seq_cyc_ctr
    import start_seq_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/start_sequencer.sv
// Runs programs 1..NPROG on a processor: Start pulse, falling edge, then waits for Done
// (ignoring a stale Done left over from the previous program) or a cycle timeout.
module start_sequencer
    import start_seq_pkg::*;
#(
    parameter int               NPROG   = DEF_NPROG,
    parameter int               START_W = DEF_START_W,
    parameter logic [CNT_W-1:0] TMO     = DEF_TMO
)
(
    input  logic Clk,
    input  logic Reset_n,
    start_sequencer_if.master sif
);

    localparam logic [1:0]       LAST_IDX = 2'(NPROG);
    localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(START_W - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic             armed;
    logic             go_acc;
    logic             done_q;
    logic             tmo_hit;

    logic             start_r;
    logic             busy_r;
    logic             cyc_vld_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [1:0]       prog_idx_r;
    logic             all_done_r;
    logic             timed_out_r;

    seq_cyc_ctr u_ctr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (state == S_LO),
        .en      (state == S_RUN),
        .cnt     (run_cnt)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IDLE;
            hi_cnt <= '0;
            armed  <= 1'b0;
        end else begin
            state  <= state_nxt;
            hi_cnt <= (state == S_HI) ? hi_cnt + 1'b1 : '0;
            if (state == S_LO)
                armed <= 1'b0;
            else if (state == S_RUN && !sif.Done)
                armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        go_acc    = 1'b0;
        done_q    = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                go_acc = sif.Go;
                if (sif.Go)
                    state_nxt = S_HI;
            end
            S_HI:   if (hi_cnt == HI_LAST) state_nxt = S_LO;
            S_LO:   state_nxt = S_RUN;
            S_RUN: begin
                // A Done arriving on the timeout cycle still counts as a finish.
                done_q  = armed && sif.Done;
                tmo_hit = !done_q && (run_cnt == TMO);
                if (done_q)
                    state_nxt = (prog_idx_r == LAST_IDX) ? S_FIN : S_HI;
                else if (tmo_hit)
                    state_nxt = S_ERR;
            end
            S_FIN:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are flops loaded from the next state, so Start/Busy track the state exactly.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
            cyc_vld_r   <= 1'b0;
            cyc_cnt_r   <= '0;
            prog_idx_r  <= 2'd0;
            all_done_r  <= 1'b0;
            timed_out_r <= 1'b0;
        end else begin
            start_r   <= (state_nxt == S_HI);
            busy_r    <= (state_nxt == S_HI) || (state_nxt == S_LO) || (state_nxt == S_RUN);
            cyc_vld_r <= done_q;
            if (done_q)
                cyc_cnt_r <= run_cnt;
            if (go_acc) begin
                prog_idx_r  <= 2'd1;
                all_done_r  <= 1'b0;
                timed_out_r <= 1'b0;
            end else if (done_q) begin
                if (prog_idx_r == LAST_IDX) begin
                    prog_idx_r <= 2'd0;
                    all_done_r <= 1'b1;
                end else begin
                    prog_idx_r <= prog_idx_r + 2'd1;
                end
            end else if (tmo_hit) begin
                prog_idx_r  <= 2'd0;
                timed_out_r <= 1'b1;
            end
        end
    end

    assign sif.Start    = start_r;
    assign sif.Busy     = busy_r;
    assign sif.CycVld   = cyc_vld_r;
    assign sif.CycCnt   = cyc_cnt_r;
    assign sif.ProgIdx  = prog_idx_r;
    assign sif.AllDone  = all_done_r;
    assign sif.TimedOut = timed_out_r;

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
- REQ-001 SHALL have parameter NPROG, default 3: number of programs run per session (1..3).
- REQ-002 SHALL have parameter START_W, default 2: Start high time in cycles (>=1).
- REQ-003 SHALL have parameter TMO, default 16'hFFFF: cycle limit per program.
- REQ-004 SHALL have port Clk, input, 1: sole clock; all state changes on posedge.
- REQ-005 SHALL have port Reset_n, input, 1: reset, asynchronous and active-low.
- REQ-006 SHALL have port Go, input, 1: one-cycle request to run programs 1..NPROG.
- REQ-007 SHALL have port Done, input, 1: processor level flag, program finished.
- REQ-008 SHALL have port Start, output, 1: launch strobe to processor program counter.
- REQ-009 SHALL have port ProgIdx, output, 2: current program number, 0 when idle.
- REQ-010 SHALL have port Busy, output, 1: session in progress.
- REQ-011 SHALL have port CycCnt, output, 16: RUN-cycle count of the last finished program.
- REQ-012 SHALL have port CycVld, output, 1: one-cycle pulse when CycCnt updates.
- REQ-013 SHALL have port AllDone, output, 1: sticky, all NPROG programs finished.
- REQ-014 SHALL have port TimedOut, output, 1: sticky, session aborted on timeout.

Function
- REQ-015 SHALL implement FSM states IDLE, HI, LO, RUN, FIN, ERR.
- REQ-016 IDLE: Go=1 -> HI, ProgIdx<=1, clear AllDone/TimedOut; Go ignored in all other states.
- REQ-017 HI: Start=1 for exactly START_W cycles, then -> LO.
- REQ-018 LO: Start=0 for exactly 1 cycle (guarantees falling edge), then -> RUN; run counter cleared to 0 and arm flag cleared.
- REQ-019 RUN: counter increments by 1 every cycle; arm flag set the first cycle Done is sampled 0.
- REQ-020 RUN: Done=1 while armed -> CycCnt<=counter value in that cycle, CycVld=1 next cycle; if ProgIdx==NPROG -> FIN, else ProgIdx+1 and -> HI.
- REQ-021 Done=1 while not armed (stale Done from previous program) SHALL be ignored.
- REQ-022 RUN: counter == TMO and no qualifying Done in same cycle -> ERR, TimedOut=1; Done in same cycle wins.
- REQ-023 Counter SHALL saturate at 16'hFFFF, never wrap.
- REQ-024 FIN: AllDone=1, ProgIdx=0, -> IDLE next cycle; AllDone held until next accepted Go.
- REQ-025 ERR: ProgIdx=0, -> IDLE next cycle; TimedOut held until next accepted Go.
- REQ-026 Busy=1 in HI, LO, RUN; 0 otherwise.
- REQ-027 Start, CycVld, Busy SHALL be registered outputs (no combinational path from inputs).

Reset
- REQ-028 Reset_n=0 SHALL immediately force IDLE, Start=0, ProgIdx=0, Busy=0, CycCnt=0, CycVld=0, AllDone=0, TimedOut=0, counter=0, arm=0, including mid-pulse or mid-RUN.
- REQ-029 First Go SHALL be honoured on the first posedge after Reset_n deasserts.

Structure
- REQ-030 Package start_seq_pkg SHALL hold state enum (3-bit), CNT_W=16, default NPROG/START_W/TMO constants.
- REQ-031 Sub-module seq_cyc_ctr SHALL implement the clearable, saturating 16-bit run counter.
- REQ-032 Block SHALL be a single clock domain; no latches.

Verification
- REQ-033 Go at cycle 5, Done rises 40 cycles after LO each program -> three Start pulses each 2 cycles high, CycCnt reported 40/40/40 via 3 CycVld pulses, AllDone=1.
- REQ-034 Done held 1 throughout HI/LO/first RUN cycles of program 2, drops, rises 10 cycles later -> stale Done ignored, CycCnt=11 for program 2.
- REQ-035 TMO=100, Done never rises -> ERR after RUN counter reaches 100, TimedOut=1, Busy=0, ProgIdx=0.
- REQ-036 Reset_n pulsed low during HI of program 2 -> Start drops asynchronously, all outputs at reset values, next Go restarts at ProgIdx=1.
- REQ-037 Go asserted during RUN and in FIN cycle -> ignored, no extra Start pulse; Go in IDLE afterward clears AllDone and starts new session.
- REQ-038 Done and counter==TMO in same RUN cycle -> program counted as finished, TimedOut stays 0.
